invert: RTL and testbench



---
 rtl/invert_pkg.sv | 7 +
 rtl/invert.sv | 19 +
 tb/tb_invert.sv | 134 +++++++++++++
 3 files changed

// File: rtl/invert_pkg.sv
// invert_pkg: state encoding shared by the bit-serial two's-complement block
package invert_pkg;
    typedef enum logic {
        PASS   = 1'b0,
        INVERT = 1'b1
    } state_t;
endpackage

// File: rtl/invert.sv
// invert: bit-serial LSB-first two's complement; r frames words and forces y low
module invert
    import invert_pkg::*;
(
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);
    state_t seen_one, seen_next;
    always_ff @(posedge t_clk) begin
        if (r) seen_one <= PASS;
        else   seen_one <= seen_next;
    end
    always_comb begin
        seen_next = (seen_one == PASS && i) ? INVERT : seen_one;
        y         = r ? 1'b0 : (seen_one == INVERT) ? ~i : i;
    end
endmodule

// File: tb/tb_invert.sv
// tb_invert: scoreboard bench; expected bits come from arithmetic negation of each word
module tb_invert;
    import invert_pkg::*;
    logic t_clk = 1'b0;
    logic r = 1'b1;
    logic i = 1'b0;
    logic y;
    int total = 0;
    int bad = 0;
    logic exp_q[$];

    invert dut (.i(i), .r(r), .t_clk(t_clk), .y(y));

    always #5 t_clk = ~t_clk;

    task automatic drive(input logic rr, input logic ii, input logic ee);
        @(negedge t_clk);
        r = rr;
        i = ii;
        exp_q.push_back(ee);
    endtask

    task automatic test_word(input string name, input logic [31:0] w, input int n);
        logic [31:0] e;
        logic eb;
        e = ~w + 32'd1;
        for (int k = -1; k < n; k++) begin
            if (k < 0) drive(1'b1, w[0], 1'b0);
            else       drive(1'b0, w[k], e[k]);
            #2;
            eb = exp_q.pop_front();
            total++;
            if (y !== eb) begin
                bad++;
                $display("FAIL %s bit %0d: y=%b want %b", name, k, y, eb);
            end
        end
    endtask

    task automatic test_reset();
        logic eb;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            #2;
            eb = exp_q.pop_front();
            total++;
            if (y !== eb) begin
                bad++;
                $display("FAIL reset y cycle %0d: y=%b want %b", k, y, eb);
            end
        end
        @(posedge t_clk);
        #1;
        total++;
        if (dut.seen_one !== PASS) begin
            bad++;
            $display("FAIL reset state: got %b want %b", dut.seen_one, PASS);
        end
    endtask

    task automatic test_value52();
        test_word("v52", 32'd52, 6);
        @(posedge t_clk);
        #1;
        total++;
        if (dut.seen_one !== INVERT) begin
            bad++;
            $display("FAIL v52 state: got %b want %b", dut.seen_one, INVERT);
        end
    endtask

    task automatic test_zero();
        test_word("zero", 32'd0, 4);
        @(posedge t_clk);
        #1;
        total++;
        if (dut.seen_one !== PASS) begin
            bad++;
            $display("FAIL zero state: got %b want %b", dut.seen_one, PASS);
        end
    endtask

    task automatic test_mid_reset();
        logic eb;
        test_word("pre_mid", 32'd1, 1);
        drive(1'b1, 1'b1, 1'b0);
        #2;
        eb = exp_q.pop_front();
        total++;
        if (y !== eb) begin
            bad++;
            $display("FAIL mid_reset during r: y=%b want %b", y, eb);
        end
        drive(1'b0, 1'b0, 1'b0);
        #2;
        eb = exp_q.pop_front();
        total++;
        if (y !== eb) begin
            bad++;
            $display("FAIL mid_reset next bit: y=%b want %b", y, eb);
        end
        @(posedge t_clk);
        #1;
        total++;
        if (dut.seen_one !== PASS) begin
            bad++;
            $display("FAIL mid_reset state: got %b want %b", dut.seen_one, PASS);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            test_word("rand", $urandom, $urandom_range(1, 32));
    endtask

    initial begin
        test_reset();
        test_value52();
        test_word("one", 32'd1, 4);
        test_zero();
        test_mid_reset();
        test_word("msb", 32'd8, 4);
        test_word("long_invert", 32'd1, 32);
        test_word("minint32", 32'h8000_0000, 32);
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover: size=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
